// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory-access stage.
// Size encodings, FSM state encoding, timeout defaults and alignment helper.
package mips_mem_pkg;

  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 7;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } mem_state_e;

  // Size 2'b11 is handled as a word access.
  function automatic logic is_misaligned(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic m;
    case (sz)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = off[0];
      default: m = |off;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_load_formatter.sv
// Load formatter: lane select of a read word plus sign/zero extension.
// Ports: rdata_i word, size_i, off_i (addr[1:0]), uns_i -> data_o.
module load_formatter
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_l;
  logic [15:0] half_l;

  always_comb begin
    byte_l = rdata_i[8*off_i +: 8];
    half_l = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o = rdata_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{byte_l[7] & ~uns_i}}, byte_l};
      SZ_HALF: data_o = {{16{half_l[15] & ~uns_i}}, half_l};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: runs loads/stores on a req/ready/rvalid data port and stalls.
// Ports: EX/MEM inputs MEM_*, MEM_rdata/mem_stall/misaligned/bus_err, dmem_*.
module mem_stage
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [1:0]  MEM_size,
  input  logic        MEM_unsigned,
  input  logic [31:0] MEM_ALU_res,
  input  logic [31:0] MEM_wdata,
  output logic [31:0] MEM_rdata,
  output logic        mem_stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  mem_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;

  logic        op;
  logic        mis_now;
  logic        tmo;
  logic [3:0]  be_new;
  logic [31:0] wd_new;
  logic [31:0] fmt;

  load_formatter u_fmt (
    .rdata_i (dmem_rdata),
    .size_i  (size_q),
    .off_i   (off_q),
    .uns_i   (uns_q),
    .data_o  (fmt)
  );

  assign op      = MEM_MemRead | MEM_MemWrite;
  assign mis_now = is_misaligned(MEM_size, MEM_ALU_res[1:0]);
  // Last allowed cycle of REQ+WAIT.
  assign tmo     = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    be_new = 4'b1111;
    wd_new = MEM_wdata;
    case (MEM_size)
      SZ_BYTE: begin
        be_new = 4'b0001 << MEM_ALU_res[1:0];
        wd_new = {4{MEM_wdata[7:0]}};
      end
      SZ_HALF: begin
        be_new = MEM_ALU_res[1] ? 4'b1100 : 4'b0011;
        wd_new = {2{MEM_wdata[15:0]}};
      end
      default: begin
        be_new = 4'b1111;
        wd_new = MEM_wdata;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    uns_d     = uns_q;
    off_d     = off_q;
    rdata_d   = rdata_q;
    mis_d     = 1'b0;
    berr_d    = 1'b0;
    mem_stall = 1'b0;
    dmem_req  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (op) begin
          if (mis_now) begin
            mis_d = 1'b1;
          end else begin
            mem_stall = 1'b1;
            // Write wins when both read and write are flagged.
            we_d      = MEM_MemWrite;
            be_d      = be_new;
            addr_d    = {MEM_ALU_res[31:2], 2'b00};
            wdata_d   = wd_new;
            size_d    = MEM_size;
            uns_d     = MEM_unsigned;
            off_d     = MEM_ALU_res[1:0];
            state_d   = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        mem_stall = 1'b1;
        dmem_req  = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (dmem_ready) begin
          state_d = we_q ? ST_DONE : ST_WAIT;
        end else if (tmo) begin
          berr_d  = 1'b1;
          state_d = ST_DONE;
          if (!we_q) rdata_d = '0;
        end
      end
      ST_WAIT: begin
        mem_stall = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (dmem_rvalid) begin
          rdata_d = fmt;
          state_d = ST_DONE;
        end else if (tmo) begin
          berr_d  = 1'b1;
          rdata_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign MEM_rdata  = rdata_q;
  assign misaligned = mis_q;
  assign bus_err    = berr_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage between the EX/MEM pipeline register and the MEM/WB register of the 5-stage MIPS pipeline.
- Runs loads and stores (byte, half, word) against a data-memory port with variable latency and a req/ready/rvalid handshake.
- Stalls the pipeline until each access completes.
- Produces the formatted load data that MEM/WB latches as MEM_rdata.

Parameters:
- TIMEOUT, 64: maximum cycles spent in REQ+WAIT before the access is aborted with bus_err.
- CNT_W, 7: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- MEM_MemRead  in  1  load in MEM stage.
- MEM_MemWrite  in  1  store in MEM stage.
- MEM_size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- MEM_unsigned  in  1  zero-extend load (lbu/lhu).
- MEM_ALU_res  in  32  effective address.
- MEM_wdata  in  32  store data from rt.
- MEM_rdata  out  32  formatted load data to MEM/WB.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; hold MEM/WB input (bubble).
- misaligned  out  1  one-cycle pulse for an unaligned access.
- bus_err  out  1  one-cycle pulse when an access times out.
- dmem_req  out  1  request valid.
- dmem_we  out  1  write request.
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ready  in  1  request accepted this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data word.

Behaviour:
- Reset: async on rst_n low; state=IDLE, counter=0. MEM_rdata=0, misaligned=0, bus_err=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0.
- Reset mid-access: the transaction is abandoned and any later rvalid is ignored in IDLE.
- Op priority: op = MemRead|MemWrite. If both are set, the write wins and the read is ignored.
- Alignment: half is unaligned when addr[0]=1; word is unaligned when addr[1:0]≠0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, aligned op present:
  - mem_stall=1 combinationally.
  - Latch we, be, addr, wdata, size, unsigned, addr[1:0].
  - Next state REQ.
- IDLE, unaligned op: misaligned=1 next cycle. No bus activity, no stall, MEM_rdata unchanged.
- IDLE, no op: mem_stall=0.
- REQ:
  - dmem_req=1 and all dmem_* stable until dmem_ready.
  - On ready: writes go to DONE, reads go to WAIT.
  - rvalid is never sampled in REQ.
- WAIT: on rvalid, capture the formatted data into MEM_rdata and go to DONE.
- Timeout: counter increments each cycle in REQ/WAIT. When it reaches TIMEOUT:
  - bus_err pulses.
  - MEM_rdata=0 for a read.
  - dmem_req drops; next state DONE.
- DONE: mem_stall=0 so the pipeline advances on this edge; next state IDLE; counter cleared.
- mem_stall=1 in REQ and WAIT.
- Latency: store 3 cycles minimum (IDLE→REQ→DONE); load 4 cycles minimum (rvalid the cycle after ready).
- Store lanes:
  - Byte: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011, wdata={2{wdata[15:0]}}.
  - Word: be=1111.
- Load format:
  - Byte lane = rdata[8*addr[1:0]+:8].
  - Half lane = addr[1] ? [31:16] : [15:0].
  - Sign-extend unless unsigned.
- MEM_rdata holds its value except on capture or timeout.
- Upstream contract: EX/MEM inputs stay constant while mem_stall=1. The stage uses latched copies regardless.

Decomposition:
- Shared package mips_mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state encoding;
  - default TIMEOUT.
- One sub-module, load_formatter: combinational lane select plus sign/zero extension, reused later for forwarding.

Test Plan:
- sw 0xDEADBEEF @0x100, ready on the 2nd REQ cycle → be=1111, addr=0x100, wdata=0xDEADBEEF; stall high 3 cycles, then DONE.
- sb 0x12345678 @0x103 → be=1000, wdata=0x78787878; lb @0x103 with rdata=0x80000000 → MEM_rdata=0xFFFFFF80; lbu gives 0x00000080.
- lh @0x102 with rdata=0x8001_0000 → MEM_rdata=0xFFFF8001; lhu gives 0x00008001.
- lw @0x102 → misaligned pulse 1 cycle, dmem_req stays 0, no stall, MEM_rdata unchanged.
- lw, ready given, rvalid withheld → bus_err at TIMEOUT (64), MEM_rdata=0, next instruction proceeds.
- rst_n low during WAIT, rvalid arrives after release → state IDLE, MEM_rdata=0, rvalid ignored.
